// File: rtl/pipelined_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipelined_hazard_ctrl
//
// Stall/flush/forward controller for the five-stage pipeline. It drives the
// load enables of the PC and the IF/ID, ID/EX and EX/MEM registers, the
// IF/ID and ID/EX bubble flushes and the MEM/WB write-suppress bubble. It also
// runs the data-memory req/ack handshake and holds registered EX operand
// forwarding selects.
//
// Optional feature macro: HAZARD_FORWARDING_EN
//   defined   : EX/MEM and MEM/WB forwarding selects. Only loads interlock.
//   undefined : FwdA/FwdB are tied to 00. Any RAW match against an EX or MEM
//               writer interlocks.
//
// Parameters
//   MEM_TIMEOUT   BUSY cycles without dmem_ack before the access is aborted
//                 (1..255)
//
// Ports
//   Clk, Clr                     clock, asynchronous active-high clear
//   ID_rs/ID_rt, ID_use_rs/rt    sources of the ID instruction and their use bits
//   EX_write_reg/Wreg/Reg2reg    EX destination, writes-register, is-load
//   MEM_write_reg/Wreg           MEM destination, writes-register
//   MEM_mem_req                  MEM instruction accesses data memory
//   EX_branch_taken              branch resolved taken in EX
//   dmem_ack                     data memory completes the access this cycle
//   PC_en .. EX_MEM_en           register load enables (combinational)
//   IF_ID_flush, ID_EX_flush     load a bubble (combinational)
//   MEM_WB_bubble                force WB_Wreg=0 on the next MEM/WB load
//   dmem_req                     data-memory request
//   FwdA, FwdB                   registered EX operand selects
//   mem_err                      sticky memory timeout flag
//   stall_cycles                 saturating count of frozen/interlocked cycles
// -----------------------------------------------------------------------------
module pipelined_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_use_rs,
  input  logic        ID_use_rt,
  input  logic [4:0]  EX_write_reg,
  input  logic        EX_Wreg,
  input  logic        EX_Reg2reg,
  input  logic [4:0]  MEM_write_reg,
  input  logic        MEM_Wreg,
  input  logic        MEM_mem_req,
  input  logic        EX_branch_taken,
  input  logic        dmem_ack,
  output logic        PC_en,
  output logic        IF_ID_en,
  output logic        ID_EX_en,
  output logic        EX_MEM_en,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        MEM_WB_bubble,
  output logic        dmem_req,
  output logic [1:0]  FwdA,
  output logic [1:0]  FwdB,
  output logic        mem_err,
  output logic [15:0] stall_cycles
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mem_state_e;

  localparam logic [7:0] TCNT_LAST = 8'(MEM_TIMEOUT - 1);

  mem_state_e state;
  logic [7:0] tcnt;

  logic mem_timeout;
  logic frozen;
  logic ex_hit;
  logic mem_hit;
  logic load_use;
  logic branch;
  logic stall_now;

  // RAW matches against the EX and MEM writers; register 0 never matches.
  always_comb begin
    ex_hit  = EX_Wreg && (EX_write_reg != 5'd0) &&
              ((ID_use_rs && (ID_rs == EX_write_reg)) ||
               (ID_use_rt && (ID_rt == EX_write_reg)));
    mem_hit = MEM_Wreg && (MEM_write_reg != 5'd0) &&
              ((ID_use_rs && (ID_rs == MEM_write_reg)) ||
               (ID_use_rt && (ID_rt == MEM_write_reg)));
  end

`ifdef HAZARD_FORWARDING_EN
  assign load_use = !Clr && ex_hit && EX_Reg2reg;
`else
  // Without forwarding every RAW dependency waits for write-back.
  assign load_use = !Clr && (ex_hit || mem_hit);
  logic unused_reg2reg;
  assign unused_reg2reg = EX_Reg2reg;
`endif

  assign branch      = !Clr && EX_branch_taken;
  assign mem_timeout = (state == BUSY) && !dmem_ack && (tcnt == TCNT_LAST);
  // The ack cycle and the timeout cycle both release the pipeline.
  assign frozen      = !Clr && (((state == IDLE) && MEM_mem_req) ||
                                ((state == BUSY) && !dmem_ack && !mem_timeout));
  // Gated by Clr so an asynchronous clear drops the request at once.
  assign dmem_req    = !Clr && (((state == IDLE) && MEM_mem_req) || (state == BUSY));
  assign stall_now   = frozen || (!branch && load_use);

  // Priority: memory freeze, then taken branch, then load-use interlock.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    PC_en         = 1'b1;
    IF_ID_en      = 1'b1;
    ID_EX_en      = 1'b1;
    EX_MEM_en     = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_flush   = 1'b0;
    MEM_WB_bubble = 1'b0;
    if (frozen) begin
      PC_en         = 1'b0;
      IF_ID_en      = 1'b0;
      ID_EX_en      = 1'b0;
      EX_MEM_en     = 1'b0;
      MEM_WB_bubble = 1'b1;
    end else if (branch) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (load_use) begin
      PC_en       = 1'b0;
      IF_ID_en    = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

  // Memory handshake FSM plus the sticky error flag and stall counter.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state        <= IDLE;
      tcnt         <= 8'd0;
      mem_err      <= 1'b0;
      stall_cycles <= 16'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (MEM_mem_req) begin
            state <= BUSY;
            tcnt  <= 8'd0;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state <= IDLE;
          end else if (tcnt == TCNT_LAST) begin
            state   <= IDLE;
            mem_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
      if (stall_now && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end

`ifdef HAZARD_FORWARDING_EN
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       ex_wreg,
    input logic [4:0] ex_wr,
    input logic       mem_wreg,
    input logic [4:0] mem_wr
  );
    if (ex_wreg && (ex_wr != 5'd0) && (src == ex_wr)) begin
      return 2'b01;
    end else if (mem_wreg && (mem_wr != 5'd0) && (src == mem_wr)) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  // Selects follow ID/EX: recomputed on a real load, cleared with a bubble,
  // held while ID/EX is frozen.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      FwdA <= 2'b00;
      FwdB <= 2'b00;
    end else if (ID_EX_en) begin
      if (ID_EX_flush) begin
        FwdA <= 2'b00;
        FwdB <= 2'b00;
      end else begin
        FwdA <= fwd_sel(ID_rs, EX_Wreg, EX_write_reg, MEM_Wreg, MEM_write_reg);
        FwdB <= fwd_sel(ID_rt, EX_Wreg, EX_write_reg, MEM_Wreg, MEM_write_reg);
      end
    end
  end
`else
  assign FwdA = 2'b00;
  assign FwdB = 2'b00;
`endif

endmodule

// File: tb/tb_pipelined_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipelined_hazard_ctrl
//
// Directed bench for pipelined_hazard_ctrl with MEM_TIMEOUT=4. A vector table
// covers single-cycle hazard decisions and forwarding selects; hand-written
// sequences cover reset, load-use follow-up, memory handshakes, timeout,
// branch under freeze, clear during an access and counter saturation.
// Expectations follow HAZARD_FORWARDING_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_pipelined_hazard_ctrl;

  logic        Clk;
  logic        Clr;
  logic [4:0]  ID_rs, ID_rt;
  logic        ID_use_rs, ID_use_rt;
  logic [4:0]  EX_write_reg;
  logic        EX_Wreg, EX_Reg2reg;
  logic [4:0]  MEM_write_reg;
  logic        MEM_Wreg, MEM_mem_req;
  logic        EX_branch_taken, dmem_ack;
  logic        PC_en, IF_ID_en, ID_EX_en, EX_MEM_en;
  logic        IF_ID_flush, ID_EX_flush, MEM_WB_bubble;
  logic        dmem_req;
  logic [1:0]  FwdA, FwdB;
  logic        mem_err;
  logic [15:0] stall_cycles;

  pipelined_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .Clk(Clk), .Clr(Clr),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
    .EX_write_reg(EX_write_reg), .EX_Wreg(EX_Wreg), .EX_Reg2reg(EX_Reg2reg),
    .MEM_write_reg(MEM_write_reg), .MEM_Wreg(MEM_Wreg), .MEM_mem_req(MEM_mem_req),
    .EX_branch_taken(EX_branch_taken), .dmem_ack(dmem_ack),
    .PC_en(PC_en), .IF_ID_en(IF_ID_en), .ID_EX_en(ID_EX_en), .EX_MEM_en(EX_MEM_en),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .MEM_WB_bubble(MEM_WB_bubble),
    .dmem_req(dmem_req), .FwdA(FwdA), .FwdB(FwdB),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, IF_ID_flush, ID_EX_flush, MEM_WB_bubble}
  localparam logic [6:0] C_NORM   = 7'b1111_000;
  localparam logic [6:0] C_LU     = 7'b0011_010;
  localparam logic [6:0] C_BRANCH = 7'b1111_110;
  localparam logic [6:0] C_FREEZE = 7'b0000_001;

  logic [6:0] ctrl;
  assign ctrl = {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, IF_ID_flush, ID_EX_flush, MEM_WB_bubble};

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_in();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_use_rs = 1'b0; ID_use_rt = 1'b0;
    EX_write_reg = 5'd0; EX_Wreg = 1'b0; EX_Reg2reg = 1'b0;
    MEM_write_reg = 5'd0; MEM_Wreg = 1'b0; MEM_mem_req = 1'b0;
    EX_branch_taken = 1'b0; dmem_ack = 1'b0;
  endtask

  // Called just after a clock edge; Clr is released well before the next edge.
  task automatic do_reset();
    clear_in();
    Clr = 1'b1;
    #2;
    Clr = 1'b0;
  endtask

  // Load to r5 in EX, ID reading rs=5.
  task automatic set_load_use();
    EX_write_reg = 5'd5; EX_Wreg = 1'b1; EX_Reg2reg = 1'b1;
    ID_rs = 5'd5; ID_use_rs = 1'b1;
  endtask

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] exw;
    logic       exwreg, exld;
    logic [4:0] memw;
    logic       memwreg, br;
    logic [6:0] ctrl_f;
    logic [1:0] fa_f, fb_f;
    logic [6:0] ctrl_n;
    logic       chk_fwd;
  } vec_t;

  vec_t vt[13];
  logic [6:0] exp_ctrl;
  logic [1:0] exp_fa, exp_fb;

  initial begin
    //           rs     rt    urs   urt   exw  wreg  ld    memw  mwreg br    ctrl_f    fa     fb     ctrl_n   chk
    vt[0]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM,   2'b00, 2'b00, C_NORM,   1'b1};
    vt[1]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5,  1'b1, 1'b1, 5'd0, 1'b0, 1'b0, C_LU,     2'b00, 2'b00, C_LU,     1'b1};
    vt[2]  = '{5'd7, 5'd6, 1'b1, 1'b1, 5'd5,  1'b1, 1'b1, 5'd0, 1'b0, 1'b0, C_NORM,   2'b00, 2'b00, C_NORM,   1'b1};
    vt[3]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0,  1'b1, 1'b1, 5'd0, 1'b0, 1'b0, C_NORM,   2'b00, 2'b00, C_NORM,   1'b1};
    vt[4]  = '{5'd1, 5'd3, 1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM,   2'b00, 2'b01, C_LU,     1'b1};
    vt[5]  = '{5'd7, 5'd2, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 5'd7, 1'b1, 1'b0, C_NORM,   2'b10, 2'b00, C_LU,     1'b1};
    vt[6]  = '{5'd4, 5'd4, 1'b1, 1'b1, 5'd4,  1'b1, 1'b0, 5'd4, 1'b1, 1'b0, C_NORM,   2'b01, 2'b01, C_LU,     1'b1};
    vt[7]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5,  1'b1, 1'b1, 5'd0, 1'b0, 1'b1, C_BRANCH, 2'b00, 2'b00, C_BRANCH, 1'b1};
    vt[8]  = '{5'd9, 5'd8, 1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 5'd8, 1'b1, 1'b0, C_NORM,   2'b01, 2'b10, C_LU,     1'b1};
    vt[9]  = '{5'd1, 5'd12,1'b1, 1'b1, 5'd12, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, C_LU,     2'b00, 2'b00, C_LU,     1'b1};
    vt[10] = '{5'd0, 5'd2, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 5'd0, 1'b1, 1'b0, C_NORM,   2'b00, 2'b00, C_NORM,   1'b1};
    vt[11] = '{5'd5, 5'd6, 1'b0, 1'b1, 5'd5,  1'b1, 1'b1, 5'd0, 1'b0, 1'b0, C_NORM,   2'b00, 2'b00, C_NORM,   1'b0};
    vt[12] = '{5'd7, 5'd2, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 5'd7, 1'b0, 1'b0, C_NORM,   2'b00, 2'b00, C_NORM,   1'b1};

    // ---------------- reset state ----------------
    clear_in();
    Clr = 1'b1;
    #2;
    check("rst_ctrl", 32'(ctrl), 32'(C_NORM));
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_fwd", 32'({FwdA, FwdB}), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_stall", 32'(stall_cycles), 32'd0);
    MEM_mem_req = 1'b1;
    set_load_use();
    #1;
    check("rst_req_masked", 32'(dmem_req), 32'd0);
    check("rst_ctrl_masked", 32'(ctrl), 32'(C_NORM));
    step();
    do_reset();

    // ---------------- vector table ----------------
    for (int i = 0; i < 13; i++) begin
      ID_rs = vt[i].rs; ID_rt = vt[i].rt; ID_use_rs = vt[i].urs; ID_use_rt = vt[i].urt;
      EX_write_reg = vt[i].exw; EX_Wreg = vt[i].exwreg; EX_Reg2reg = vt[i].exld;
      MEM_write_reg = vt[i].memw; MEM_Wreg = vt[i].memwreg; EX_branch_taken = vt[i].br;
      exp_ctrl = FWD ? vt[i].ctrl_f : vt[i].ctrl_n;
      exp_fa   = FWD ? vt[i].fa_f : 2'b00;
      exp_fb   = FWD ? vt[i].fb_f : 2'b00;
      #1;
      check($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(exp_ctrl));
      step();
      if (vt[i].chk_fwd) begin
        check($sformatf("vec%0d_fwdA", i), 32'(FwdA), 32'(exp_fa));
        check($sformatf("vec%0d_fwdB", i), 32'(FwdB), 32'(exp_fb));
      end
    end

    // ---------------- load-use then forward from MEM ----------------
    do_reset();
    set_load_use();
    #1;
    check("lu_ctrl", 32'(ctrl), 32'(C_LU));
    step();
    check("lu_stall1", 32'(stall_cycles), 32'd1);
    check("lu_fwdA_bubble", 32'(FwdA), 32'd0);
    clear_in();
    ID_rs = 5'd5; ID_use_rs = 1'b1;
    MEM_write_reg = 5'd5; MEM_Wreg = 1'b1;
    #1;
    check("lu_next_ctrl", 32'(ctrl), 32'(FWD ? C_NORM : C_LU));
    step();
    check("lu_next_fwdA", 32'(FwdA), FWD ? 32'd2 : 32'd0);
    check("lu_next_stall", 32'(stall_cycles), FWD ? 32'd1 : 32'd2);

    // ---------------- memory access, ack in BUSY cycle 3, back-to-back ----------------
    do_reset();
    MEM_mem_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("mem_frz%0d_ctrl", c), 32'(ctrl), 32'(C_FREEZE));
      check($sformatf("mem_frz%0d_req", c), 32'(dmem_req), 32'd1);
      step();
    end
    dmem_ack = 1'b1;
    #1;
    check("mem_ack_ctrl", 32'(ctrl), 32'(C_NORM));
    check("mem_ack_req", 32'(dmem_req), 32'd1);
    step();
    dmem_ack = 1'b0;
    #1;
    check("b2b_req", 32'(dmem_req), 32'd1);
    check("b2b_ctrl", 32'(ctrl), 32'(C_FREEZE));
    step();
    dmem_ack = 1'b1;
    #1;
    check("b2b_min_ack_ctrl", 32'(ctrl), 32'(C_NORM));
    step();
    MEM_mem_req = 1'b0;
    #1;
    check("idle_ack_ignored_req", 32'(dmem_req), 32'd0);
    check("idle_ack_ignored_ctrl", 32'(ctrl), 32'(C_NORM));
    check("mem_stall_count", 32'(stall_cycles), 32'd4);
    check("mem_no_err", 32'(mem_err), 32'd0);

    // ---------------- timeout, MEM_TIMEOUT=4 ----------------
    do_reset();
    MEM_mem_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("to_frz%0d_ctrl", c), 32'(ctrl), 32'(C_FREEZE));
      step();
    end
    #1;
    check("to_release_ctrl", 32'(ctrl), 32'(C_NORM));
    check("to_err_before_edge", 32'(mem_err), 32'd0);
    step();
    MEM_mem_req = 1'b0;
    dmem_ack = 1'b1;
    #1;
    check("to_err_set", 32'(mem_err), 32'd1);
    check("to_late_ack_req", 32'(dmem_req), 32'd0);
    check("to_late_ack_ctrl", 32'(ctrl), 32'(C_NORM));
    check("to_stall_count", 32'(stall_cycles), 32'd4);
    step();
    step();
    check("to_err_sticky", 32'(mem_err), 32'd1);
    do_reset();
    #1;
    check("to_err_cleared", 32'(mem_err), 32'd0);
    step();

    // ---------------- branch + load-use under freeze ----------------
    do_reset();
    EX_write_reg = 5'd3; EX_Wreg = 1'b1; ID_rt = 5'd3; ID_use_rt = 1'b1;
    step();
    check("brf_fwdB_setup", 32'(FwdB), FWD ? 32'd1 : 32'd0);
    MEM_mem_req = 1'b1;
    set_load_use();
    EX_branch_taken = 1'b1;
    #1;
    check("brf_frozen_ctrl", 32'(ctrl), 32'(C_FREEZE));
    step();
    check("brf_fwdB_hold", 32'(FwdB), FWD ? 32'd1 : 32'd0);
    dmem_ack = 1'b1;
    #1;
    check("brf_release_ctrl", 32'(ctrl), 32'(C_BRANCH));
    step();
    check("brf_fwd_cleared", 32'({FwdA, FwdB}), 32'd0);

    // ---------------- load-use under freeze: bubble on release ----------------
    do_reset();
    MEM_mem_req = 1'b1;
    set_load_use();
    #1;
    check("luf_frozen_ctrl", 32'(ctrl), 32'(C_FREEZE));
    step();
    dmem_ack = 1'b1;
    #1;
    check("luf_release_ctrl", 32'(ctrl), 32'(C_LU));
    step();
    check("luf_stall_count", 32'(stall_cycles), 32'd2);

    // ---------------- clear during BUSY ----------------
    do_reset();
    MEM_mem_req = 1'b1;
    step();
    check("clr_busy_pre_stall", 32'(stall_cycles), 32'd1);
    check("clr_busy_pre_req", 32'(dmem_req), 32'd1);
    Clr = 1'b1;
    #1;
    check("clr_busy_req", 32'(dmem_req), 32'd0);
    check("clr_busy_ctrl", 32'(ctrl), 32'(C_NORM));
    check("clr_busy_stall", 32'(stall_cycles), 32'd0);
    check("clr_busy_fwd", 32'({FwdA, FwdB}), 32'd0);
    Clr = 1'b0;
    MEM_mem_req = 1'b0;
    #1;
    check("clr_busy_idle", 32'(dmem_req), 32'd0);
    step();

    // ---------------- stall counter saturation ----------------
    do_reset();
    set_load_use();
    repeat (65540) @(posedge Clk);
    #1;
    check("stall_saturate", 32'(stall_cycles), 32'hFFFF);
    step();
    check("stall_hold_sat", 32'(stall_cycles), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
